// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle and holds loads in
// WAIT_LOAD until the data memory responds, aligning and extending the word
// before writing the register file.
// Optional feature macro: WB_LOAD_TIMEOUT_EN (abort a load after
// TIMEOUT_CYCLES cycles without a response and raise a sticky load_fault).
module wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [4:0]  rd_i,
    input  logic        rd_we_i,
    input  logic [31:0] alu_result_i,
    input  logic        is_load_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  a_rd,
    output logic [31:0] d_rd,
    output logic        we_rd,
    output logic        load_fault
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic [4:0]  a_rd_q;
    logic [31:0] d_rd_q;
    logic        we_rd_q;

    // Pending load captured at the handshake.
    logic [4:0]  pend_rd_q;
    logic        pend_we_q;
    logic [2:0]  pend_f3_q;
    logic [1:0]  pend_addr_q;

    logic [31:0] load_data_c;

    // Select the addressed byte/halfword and extend it according to funct3.
    function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                               input logic [1:0]  addr,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_align = {{24{b[7]}}, b};
            3'b100:  load_align = {24'd0, b};
            3'b001:  load_align = {{16{h[15]}}, h};
            3'b101:  load_align = {16'd0, h};
            default: load_align = word;
        endcase
    endfunction

    // Aligned load result for the pending instruction.
    always_comb begin
        load_data_c = load_align(pend_f3_q, pend_addr_q, dmem_rdata);
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
`else
    // Timeout length only matters when the abort logic is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Handshake FSM, writeback port and optional load timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            a_rd_q      <= 5'd0;
            d_rd_q      <= 32'd0;
            we_rd_q     <= 1'b0;
            pend_rd_q   <= 5'd0;
            pend_we_q   <= 1'b0;
            pend_f3_q   <= 3'd0;
            pend_addr_q <= 2'd0;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_q       <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            we_rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (is_load_i) begin
                            pend_rd_q   <= rd_i;
                            pend_we_q   <= rd_we_i;
                            pend_f3_q   <= funct3_i;
                            pend_addr_q <= addr_lo_i;
                            state_q     <= ST_WAIT;
                            ready_q     <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end else begin
                            a_rd_q  <= rd_i;
                            d_rd_q  <= alu_result_i;
                            we_rd_q <= rd_we_i && (rd_i != 5'd0);
                        end
                    end
                end
                ST_WAIT: begin
                    // A response on the expiry edge still wins over the abort.
                    if (dmem_rvalid) begin
                        a_rd_q  <= pend_rd_q;
                        d_rd_q  <= load_data_c;
                        we_rd_q <= pend_we_q && (pend_rd_q != 5'd0);
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        fault_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign a_rd    = a_rd_q;
    assign d_rd    = d_rd_q;
    assign we_rd   = we_rd_q;
`ifdef WB_LOAD_TIMEOUT_EN
    assign load_fault = fault_q;
`else
    assign load_fault = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes the register writes it
// expects, a negedge monitor pops and compares every we_rd pulse.
module tb_wb_stage;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic [31:0] alu_result_i;
    logic        is_load_i;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lo_i;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  a_rd;
    logic [31:0] d_rd;
    logic        we_rd;
    logic        load_fault;

    wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rd_i         (rd_i),
        .rd_we_i      (rd_we_i),
        .alu_result_i (alu_result_i),
        .is_load_i    (is_load_i),
        .funct3_i     (funct3_i),
        .addr_lo_i    (addr_lo_i),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .a_rd         (a_rd),
        .d_rd         (d_rd),
        .we_rd        (we_rd),
        .load_fault   (load_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [4:0]  last_a;
    logic [31:0] last_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference load result: shift the word down to the addressed lane, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr, input logic [31:0] w);
        logic [31:0] sh;
        int          v;
        case (f3)
            3'b000: begin sh = w >> (8 * addr);         v = int'($signed(sh[7:0]));  return 32'(v); end
            3'b100: begin sh = w >> (8 * addr);         return sh & 32'h0000_00FF; end
            3'b001: begin sh = w >> (16 * (addr / 2));  v = int'($signed(sh[15:0])); return 32'(v); end
            3'b101: begin sh = w >> (16 * (addr / 2));  return sh & 32'h0000_FFFF; end
            default: return w;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Non-load transfer; valid_i is left high so callers can chain back-to-back.
    task automatic send_alu(input logic [4:0] rd, input logic we, input logic [31:0] data, input logic stray);
        valid_i      = 1'b1;
        is_load_i    = 1'b0;
        rd_i         = rd;
        rd_we_i      = we;
        alu_result_i = data;
        funct3_i     = 3'($urandom_range(0, 7));
        addr_lo_i    = 2'($urandom_range(0, 3));
        dmem_rvalid  = stray;
        dmem_rdata   = $urandom;
        check("alu_ready", 32'(ready_o), 32'd1);
        if (we && rd != 5'd0) exp_q.push_back('{rd, data});
        step();
        dmem_rvalid = 1'b0;
        check("alu_a_rd", 32'(a_rd), 32'(rd));
        check("alu_d_rd", d_rd, data);
        last_a = rd;
        last_d = data;
    endtask

    // Load transfer, then response after 'delay' WAIT_LOAD cycles.
    task automatic send_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                             input logic [1:0] addr, input logic [31:0] word, input int delay);
        logic [31:0] e;
        valid_i      = 1'b1;
        is_load_i    = 1'b1;
        rd_i         = rd;
        rd_we_i      = we;
        funct3_i     = f3;
        addr_lo_i    = addr;
        alu_result_i = $urandom;
        dmem_rvalid  = 1'b0;
        step();
        valid_i      = 1'b0;
        is_load_i    = 1'b0;
        rd_i         = 5'($urandom_range(0, 31));
        funct3_i     = 3'($urandom_range(0, 7));
        addr_lo_i    = 2'($urandom_range(0, 3));
        for (int i = 0; i < delay; i++) begin
            check("wait_ready", 32'(ready_o), 32'd0);
            check("wait_hold_a", 32'(a_rd), 32'(last_a));
            step();
        end
        check("resp_cycle_ready", 32'(ready_o), 32'd0);
        e = ref_load(f3, int'(addr), word);
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        if (we && rd != 5'd0) exp_q.push_back('{rd, e});
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        check("load_done_ready", 32'(ready_o), 32'd1);
        check("load_a_rd", 32'(a_rd), 32'(rd));
        check("load_d_rd", d_rd, e);
        last_a = rd;
        last_d = e;
    endtask

    // Idle cycle with a possible stray response that must be ignored.
    task automatic idle_cycle();
        valid_i     = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        step();
        dmem_rvalid = 1'b0;
        check("idle_ready", 32'(ready_o), 32'd1);
        check("idle_hold_a", 32'(a_rd), 32'(last_a));
        check("idle_hold_d", d_rd, last_d);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (we_rd === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got a_rd=%0d d_rd=0x%08h, expected no write", a_rd, d_rd);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(a_rd), 32'(e.a));
                check("wr_data", d_rd, e.d);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        valid_i      = 1'b0;
        rd_i         = 5'd0;
        rd_we_i      = 1'b0;
        alu_result_i = 32'd0;
        is_load_i    = 1'b0;
        funct3_i     = 3'd0;
        addr_lo_i    = 2'd0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'd0;
        last_a       = 5'd0;
        last_d       = 32'd0;
        step();
        step();
        check("rst_we", 32'(we_rd), 32'd0);
        check("rst_a", 32'(a_rd), 32'd0);
        check("rst_d", d_rd, 32'd0);
        check("rst_fault", 32'(load_fault), 32'd0);
        reset = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        idle_cycle();

        // Single ALU write to x5.
        send_alu(5'd5, 1'b1, 32'h1234_5678, 1'b0);
        valid_i = 1'b0;
        idle_cycle();

        // Directed alignment cases.
        send_load(5'd10, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 0);
        check("lb_val", d_rd, 32'hFFFF_FF80);
        send_load(5'd10, 1'b1, 3'b100, 2'd3, 32'h80FF_0000, 1);
        check("lbu_val", d_rd, 32'h0000_0080);
        send_load(5'd10, 1'b1, 3'b001, 2'd2, 32'h80FF_0000, 0);
        check("lh_val", d_rd, 32'hFFFF_80FF);
        send_load(5'd10, 1'b1, 3'b101, 2'd3, 32'h80FF_0000, 2);
        check("lhu_val", d_rd, 32'h0000_80FF);

        // Load to x7 with a delayed response.
        send_load(5'd7, 1'b1, 3'b010, 2'd1, 32'hCAFE_F00D, 3);

        // x0 write suppressed, following x1 write unaffected, no bubble.
        send_alu(5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        send_alu(5'd1, 1'b1, 32'h0000_0011, 1'b1);
        send_alu(5'd2, 1'b1, 32'h0000_0022, 1'b0);
        valid_i = 1'b0;
        idle_cycle();

        // Randomized mix of ALU bursts, loads and idle cycles.
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++)
                    send_alu(5'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
                             $urandom, 1'($urandom_range(0, 1)));
                valid_i = 1'b0;
            end else if (kind == 1) begin
                send_load(5'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          $urandom, int'($urandom_range(0, 5)));
            end else begin
                idle_cycle();
            end
        end

        // Reset in WAIT_LOAD together with a response: the load is dropped.
        valid_i   = 1'b1;
        is_load_i = 1'b1;
        rd_i      = 5'd9;
        rd_we_i   = 1'b1;
        funct3_i  = 3'b010;
        step();
        valid_i   = 1'b0;
        is_load_i = 1'b0;
        step();
        reset       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        step();
        reset       = 1'b0;
        dmem_rvalid = 1'b0;
        check("rstw_ready", 32'(ready_o), 32'd1);
        check("rstw_we", 32'(we_rd), 32'd0);
        check("rstw_a", 32'(a_rd), 32'd0);
        check("rstw_d", d_rd, 32'd0);
        check("rstw_fault", 32'(load_fault), 32'd0);
        last_a = 5'd0;
        last_d = 32'd0;
        idle_cycle();

`ifdef WB_LOAD_TIMEOUT_EN
        // Response on the expiry edge wins.
        send_load(5'd12, 1'b1, 3'b010, 2'd0, 32'h0BAD_F00D, int'(TO) - 1);
        check("prio_fault", 32'(load_fault), 32'd0);
        // No response: abort after TO WAIT_LOAD cycles, sticky fault.
        valid_i   = 1'b1;
        is_load_i = 1'b1;
        rd_i      = 5'd13;
        rd_we_i   = 1'b1;
        step();
        valid_i   = 1'b0;
        is_load_i = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            check("to_wait_ready", 32'(ready_o), 32'd0);
            step();
        end
        check("to_ready", 32'(ready_o), 32'd1);
        check("to_fault", 32'(load_fault), 32'd1);
        check("to_no_write_a", 32'(a_rd), 32'(last_a));
        send_alu(5'd3, 1'b1, 32'h0000_0333, 1'b0);
        valid_i = 1'b0;
        check("to_fault_sticky", 32'(load_fault), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("to_fault_cleared", 32'(load_fault), 32'd0);
        last_a = 5'd0;
        last_d = 32'd0;
`else
        // Without the timeout the stage waits well past TO cycles.
        send_load(5'd13, 1'b1, 3'b010, 2'd0, 32'h0BAD_F00D, int'(TO) + 4);
        check("nto_fault", 32'(load_fault), 32'd0);
`endif
        idle_cycle();
        idle_cycle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning WAIT_LOAD cycles before abort (used only with WB_LOAD_TIMEOUT_EN).
REQ-002 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  upstream result present; ready_o  output  1  stage can accept.
REQ-005 rd_i  input  5  destination register; rd_we_i  input  1  instruction writes rd.
REQ-006 alu_result_i  input  32  non-load result; is_load_i  input  1  instruction is a load.
REQ-007 funct3_i  input  3  load width/sign; addr_lo_i  input  2  load byte offset.
REQ-008 dmem_rvalid  input  1  load data valid; dmem_rdata  input  32  raw memory word.
REQ-009 a_rd  output  5, d_rd  output  32, we_rd  output  1: regfile write port.
REQ-010 load_fault  output  1  sticky load-timeout flag.
REQ-011 One clock domain; reset is synchronous and active-high.

Function
REQ-012 SHALL implement FSM states IDLE and WAIT_LOAD; ready_o = 1 exactly when state is IDLE.
REQ-013 Transfer occurs on a rising edge where valid_i and ready_o are both 1.
REQ-014 Non-load transfer at edge N: a_rd=rd_i, d_rd=alu_result_i, we_rd=1 for the single cycle after N; state stays IDLE.
REQ-015 Load transfer: capture rd_i, rd_we_i, funct3_i, addr_lo_i; go to WAIT_LOAD; we_rd=0.
REQ-016 In WAIT_LOAD, edge with dmem_rvalid=1: write aligned data with we_rd=1 for one cycle, return to IDLE; ready_o=1 in that same cycle.
REQ-017 Data memory response SHALL arrive no earlier than the cycle after the load transfer; dmem_rvalid in IDLE SHALL be ignored.
REQ-018 Alignment: LB(000)/LBU(100) select byte addr_lo; LH(001)/LHU(101) select halfword addr_lo[1], addr_lo[0] ignored; LW(010) full word, addr_lo ignored.
REQ-019 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; funct3 011/110/111 SHALL behave as LW.
REQ-020 rd=0 or rd_we=0: we_rd SHALL stay 0; a_rd/d_rd still update, and the handshake/FSM proceed normally.
REQ-021 we_rd SHALL never be 1 for two consecutive cycles from one instruction.
REQ-022 Back-to-back non-load transfers SHALL produce one write per cycle with no bubble.
REQ-023 a_rd and d_rd hold their last value while we_rd=0.

Reset
REQ-024 On reset edge: state=IDLE, we_rd=0, a_rd=0, d_rd=0, load_fault=0, timeout counter=0.
REQ-025 Reset during WAIT_LOAD SHALL discard the pending load; no write occurs, including when dmem_rvalid is also 1.
REQ-026 ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With macro WB_LOAD_TIMEOUT_EN defined: counter increments each WAIT_LOAD cycle without dmem_rvalid; when TIMEOUT_CYCLES elapse, return to IDLE, no write, set load_fault=1 until reset.
REQ-028 dmem_rvalid on the same edge as expiry SHALL take priority: the write completes and load_fault is not set.
REQ-029 Without WB_LOAD_TIMEOUT_EN: WAIT_LOAD waits indefinitely; load_fault tied to 0; no counter logic.

Verification
REQ-030 ALU result x5=0x12345678, valid for 1 cycle -> next cycle we_rd=1, a_rd=5, d_rd=0x12345678, then we_rd=0.
REQ-031 LB, addr_lo=3, rdata=0x80FF_0000 -> d_rd=0xFFFFFF80; LBU same -> 0x00000080; LH addr_lo=2 -> 0xFFFF80FF; LHU -> 0x000080FF.
REQ-032 Load to x7, dmem_rvalid delayed 3 cycles -> ready_o=0 for 3 cycles, then one write to x7 and ready_o=1.
REQ-033 Write to x0 with alu_result=0xDEADBEEF -> we_rd stays 0; following ALU write to x1 proceeds unchanged.
REQ-034 Reset asserted during WAIT_LOAD together with dmem_rvalid -> no write, state IDLE, all outputs at reset values.
REQ-035 WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no dmem_rvalid -> after 16 WAIT_LOAD cycles ready_o=1, load_fault=1, no write; without macro ready_o stays 0.
